// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg -- shared size codes, device base, FSM encoding and fault check.
// Rev 1.0
`default_nettype none

package mem_access_unit_pkg;

  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 16;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int DEVICE_BASE = 8192;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    RD_WAIT  = 3'd2,
    WR       = 3'd3,
    RMW_RD   = 3'd4,
    RMW_WAIT = 3'd5,
    RMW_WR   = 3'd6,
    RESP     = 3'd7
  } mau_state_t;

  // Size 3 is never legal; halves need even addresses, words need 4-byte alignment.
  function automatic logic access_fault(input logic [1:0] size, input logic [1:0] addr_lo);
    logic fault;
    case (size)
      SIZE_B:  fault = 1'b0;
      SIZE_H:  fault = addr_lo[0];
      SIZE_W:  fault = (addr_lo != 2'b00);
      default: fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if -- request channel plus single-port memory bus of the access unit.
// Rev 1.0
`default_nettype none

interface mem_access_unit_if
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = WIDTH,
  parameter int ADDR_W = ADDR_WIDTH
);

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [1:0]        req_size_i;
  logic              req_unsigned_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic              resp_valid_o;
  logic [DATA_W-1:0] resp_rdata_o;
  logic              resp_err_o;
  logic              memread_o;
  logic              memwrite_o;
  logic [ADDR_W-1:0] memaddr_o;
  logic [DATA_W-1:0] memwdata_o;
  logic [DATA_W-1:0] memrdata_i;

  // The access unit itself.
  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  memrdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    output memread_o, memwrite_o, memaddr_o, memwdata_o
  );

  // The pipeline and memory surrounding it.
  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output memrdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
    input  memread_o, memwrite_o, memaddr_o, memwdata_o
  );

endinterface

`default_nettype wire

// File: rtl/mem_access_unit_lane_align.sv
// mau_lane_align -- little-endian lane extract/extend for loads, lane merge and zero-extend for stores.
// Rev 1.0
`default_nettype none

module mau_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = WIDTH
) (
  input  logic [1:0]        size,
  input  logic [1:0]        lane,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] rdata_word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged_word,
  output logic [DATA_W-1:0] store_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel    = rdata_word[{lane, 3'b000} +: 8];
    half_sel    = rdata_word[{lane[1], 4'b0000} +: 16];
    load_data   = rdata_word;
    merged_word = wdata;
    store_ext   = wdata;
    case (size)
      SIZE_B: begin
        load_data   = {{(DATA_W-8){~is_unsigned & byte_sel[7]}}, byte_sel};
        merged_word = rdata_word;
        merged_word[{lane, 3'b000} +: 8] = wdata[7:0];
        store_ext   = {{(DATA_W-8){1'b0}}, wdata[7:0]};
      end
      SIZE_H: begin
        load_data   = {{(DATA_W-16){~is_unsigned & half_sel[15]}}, half_sel};
        merged_word = rdata_word;
        merged_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        store_ext   = {{(DATA_W-16){1'b0}}, wdata[15:0]};
      end
      default: begin
        load_data   = rdata_word;
        merged_word = wdata;
        store_ext   = wdata;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// mem_access_unit -- one-at-a-time load/store initiator with sub-word RMW on a word-wide memory bus.
// Rev 1.0
`default_nettype none

module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = WIDTH,
  parameter int ADDR_W = ADDR_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  mem_access_unit_if.slave bus
);

  localparam logic [ADDR_W-1:0] DEV_BASE = ADDR_W'(DEVICE_BASE);

  mau_state_t state, state_next;

  logic              ready, ready_next;
  logic              resp_valid, resp_valid_next;
  logic [DATA_W-1:0] resp_rdata, resp_rdata_next;
  logic              resp_err, resp_err_next;
  logic              memread, memread_next;
  logic              memwrite, memwrite_next;
  logic [ADDR_W-1:0] memaddr, memaddr_next;
  logic [DATA_W-1:0] memwdata, memwdata_next;

  logic [1:0]        cap_size, cap_size_next;
  logic [1:0]        cap_lane, cap_lane_next;
  logic              cap_unsigned, cap_unsigned_next;
  logic [DATA_W-1:0] cap_wdata, cap_wdata_next;

  logic              accept;
  logic              is_device;
  logic [1:0]        align_size;
  logic [1:0]        align_lane;
  logic              align_unsigned;
  logic [DATA_W-1:0] align_wdata;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] store_ext;

  assign accept    = (state == IDLE) && ready && bus.req_valid_i;
  assign is_device = (bus.req_addr_i >= DEV_BASE);

  // In IDLE the aligner sees the live request so a direct store can be zero-extended on accept.
  assign align_size     = (state == IDLE) ? bus.req_size_i       : cap_size;
  assign align_lane     = (state == IDLE) ? bus.req_addr_i[1:0]  : cap_lane;
  assign align_unsigned = (state == IDLE) ? bus.req_unsigned_i   : cap_unsigned;
  assign align_wdata    = (state == IDLE) ? bus.req_wdata_i      : cap_wdata;

  mau_lane_align #(
    .DATA_W (DATA_W)
  ) u_lane_align (
    .size        (align_size),
    .lane        (align_lane),
    .is_unsigned (align_unsigned),
    .rdata_word  (bus.memrdata_i),
    .wdata       (align_wdata),
    .load_data   (load_data),
    .merged_word (merged_word),
    .store_ext   (store_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ready        <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      memread      <= 1'b0;
      memwrite     <= 1'b0;
      memaddr      <= '0;
      memwdata     <= '0;
      cap_size     <= '0;
      cap_lane     <= '0;
      cap_unsigned <= 1'b0;
      cap_wdata    <= '0;
    end else begin
      state        <= state_next;
      ready        <= ready_next;
      resp_valid   <= resp_valid_next;
      resp_rdata   <= resp_rdata_next;
      resp_err     <= resp_err_next;
      memread      <= memread_next;
      memwrite     <= memwrite_next;
      memaddr      <= memaddr_next;
      memwdata     <= memwdata_next;
      cap_size     <= cap_size_next;
      cap_lane     <= cap_lane_next;
      cap_unsigned <= cap_unsigned_next;
      cap_wdata    <= cap_wdata_next;
    end
  end

  // Every output register is loaded with the value it must show in the state being entered.
  always_comb begin
    state_next        = state;
    resp_valid_next   = 1'b0;
    resp_rdata_next   = '0;
    resp_err_next     = 1'b0;
    memread_next      = 1'b0;
    memwrite_next     = 1'b0;
    memaddr_next      = memaddr;
    memwdata_next     = '0;
    cap_size_next     = cap_size;
    cap_lane_next     = cap_lane;
    cap_unsigned_next = cap_unsigned;
    cap_wdata_next    = cap_wdata;

    case (state)
      IDLE: begin
        if (accept) begin
          cap_size_next     = bus.req_size_i;
          cap_lane_next     = bus.req_addr_i[1:0];
          cap_unsigned_next = bus.req_unsigned_i;
          cap_wdata_next    = bus.req_wdata_i;
          memaddr_next      = {bus.req_addr_i[ADDR_W-1:2], 2'b00};
          if (access_fault(bus.req_size_i, bus.req_addr_i[1:0])) begin
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
          end else if (!bus.req_we_i) begin
            state_next   = RD;
            memread_next = 1'b1;
          end else if ((bus.req_size_i == SIZE_W) || is_device) begin
            // Device registers are never merged: their read value is not memory contents.
            state_next    = WR;
            memwrite_next = 1'b1;
            memwdata_next = store_ext;
          end else begin
            state_next   = RMW_RD;
            memread_next = 1'b1;
          end
        end
      end
      RD: begin
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        state_next      = RESP;
        resp_valid_next = 1'b1;
        resp_rdata_next = load_data;
      end
      WR: begin
        state_next      = RESP;
        resp_valid_next = 1'b1;
      end
      RMW_RD: begin
        state_next = RMW_WAIT;
      end
      RMW_WAIT: begin
        state_next    = RMW_WR;
        memwrite_next = 1'b1;
        memwdata_next = merged_word;
      end
      RMW_WR: begin
        state_next      = RESP;
        resp_valid_next = 1'b1;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    ready_next = (state_next == IDLE);
  end

  assign bus.req_ready_o  = ready;
  assign bus.resp_valid_o = resp_valid;
  assign bus.resp_rdata_o = resp_rdata;
  assign bus.resp_err_o   = resp_err;
  assign bus.memread_o    = memread;
  assign bus.memwrite_o   = memwrite;
  assign bus.memaddr_o    = memaddr;
  assign bus.memwdata_o   = memwdata;

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

CPU-side initiator for the unified memory interface: accepts one load/store at a time from the execute stage over a valid/ready handshake and drives the single-port memory bus (`memread`/`memwrite`/`memaddr`/`memwdata`/`memrdata`). The memory behind that bus is word-wide with one-cycle read latency. This block adds byte/halfword access on top of it: lane extraction with sign/zero extension for loads, read-modify-write for sub-word stores to RAM, and a misalignment error. It sits between the pipeline's MEM stage and the memory module.

## Interface
- `DATA_W`, default `` `WIDTH `` (32): data width.
- `ADDR_W`, default `` `ADDR_WIDTH ``: byte-address width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: block can accept a request.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_size_i` in 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned_i` in 1: zero-extend sub-word loads.
- `req_addr_i` in ADDR_W: byte address.
- `req_wdata_i` in DATA_W: store data, right-aligned.
- `resp_valid_o` out 1: one-cycle completion pulse.
- `resp_rdata_o` out DATA_W: load result; 0 for stores and errors.
- `resp_err_o` out 1: misaligned or illegal size; valid with `resp_valid_o`.
- `memread_o` out 1: memory read strobe.
- `memwrite_o` out 1: memory write strobe.
- `memaddr_o` out ADDR_W: word-aligned address (bits [1:0] = 0).
- `memwdata_o` out DATA_W: write data.
- `memrdata_i` in DATA_W: read data, valid the cycle after `memread_o`.

## Operation
- **Handshake and outputs**
  - A request is accepted when `req_valid_i & req_ready_o`. All request fields are captured at that edge.
  - `req_ready_o` = 1 only in IDLE.
  - All outputs are registered. Reset value of every output is 0, and state returns to IDLE.
- **Error check**
  - An error is raised for: size 3; half with `addr[0]`=1; word with `addr[1:0]`≠0.
  - On error: go to RESP with `resp_err_o`=1. No memory strobe is issued.
- **Lanes (little-endian)**
  - Byte k occupies bits [8k+7:8k], with k = `addr[1:0]`.
  - Half occupies bits [16h+15:16h], with h = `addr[1]`.
- **Loads:** IDLE → RD (`memread_o`=1) → RD_WAIT (capture `memrdata_i`, extract lane, sign- or zero-extend) → RESP → IDLE.
- **Word store, or any store with addr ≥ `DEVICE_BASE` (8192):** IDLE → WR (`memwrite_o`=1) → RESP.
  - In the device region, sub-word data is written zero-extended as a full word, with no RMW. Device reads return button state and must never be merged.
- **Sub-word store below `DEVICE_BASE`:** IDLE → RMW_RD (`memread_o`) → RMW_WAIT (merge `req_wdata` low bits into the addressed lane of `memrdata_i`) → RMW_WR (`memwrite_o`, merged word) → RESP.
- **Strobe and bus rules**
  - `memread_o` and `memwrite_o` are never high together. Each is high for exactly one cycle per access.
  - `memaddr_o` is stable from the issue cycle through RESP.
  - `memwdata_o` is 0 except in WR/RMW_WR.
- **RESP:** `resp_valid_o`=1 for one cycle, then IDLE.
- **Reset mid-operation:** the transaction is dropped and no response is produced. A write strobe already high in the reset cycle still commits at that edge.

## Timing
- Handshake in cycle N. Responses arrive at:
  - Load: `memread_o` in N+1, data sampled in N+2, `resp_valid_o` in N+3.
  - Word/device store: `memwrite_o` in N+1, `resp_valid_o` in N+2.
  - RMW store: read in N+1, merge in N+2, write in N+3, resp in N+4.
  - Error: `resp_valid_o` in N+1.
- Next accept is possible in the cycle after RESP. Back-to-back loads therefore accept every 4 cycles.
- `req_valid_i` low in IDLE: no bus activity.

## Structure
- The shared defines header holds:
  - size codes `SIZE_B`/`SIZE_H`/`SIZE_W`;
  - `DEVICE_BASE` (8192);
  - state encodings IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_WAIT, RMW_WR, RESP.
- One combinational sub-module, `mau_lane_align`, performs load extract/extend and store merge. The FSM lives in `mem_access_unit`.

## Test plan
- **Load byte, signed:** word 0x1000 = 0x80FF7F01; load byte signed at 0x1003 → `resp_rdata_o`=0xFFFFFF80 at N+3. Unsigned at 0x1002 → 0x000000FF.
- **Load half, signed:** load half signed at 0x1002 → 0xFFFF80FF. `memaddr_o`=0x1000 and a single `memread_o` pulse at N+1.
- **Store byte with RMW:** store byte 0xAB at 0x1001 over 0x11223344 → read at N+1, `memwrite_o` at N+3 with 0x1122AB44, `resp_valid_o` at N+4. A reload returns 0x1122AB44.
- **Store half, device region:** store half 0x1234 at 0xFFF0 → `memwrite_o` at N+1 with `memwdata_o`=0x00001234, no `memread_o`, resp at N+2.
- **Misaligned:** word load at 0x1002 → `resp_err_o`=1 at N+1, no strobe. Half store at 0x1001 → same.
- **Reset mid-operation:** `rst` asserted during RMW_WAIT → no `memwrite_o`, no `resp_valid_o`, all outputs 0 next cycle, `req_ready_o`=1 after `rst` falls.
